// File: rtl/gb_cmd_master_pkg.sv
// Shared types and defaults for the ghostbus host-side command master.
package gb_cmd_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_RWAIT = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } gb_state_e;

  localparam int GB_READ_DELAY_DEFAULT = 3;
  localparam int GB_GAP_CYCLES_DEFAULT = 1;

endpackage

// File: rtl/gb_cmd_master.sv
// Ghostbus command master: turns a valid/ready command stream into single-cycle
// gb_wen/gb_rstb strobes and returns one in-order response per command.
module gb_cmd_master
  import gb_cmd_master_pkg::*;
#(
  parameter int GB_AW      = 24,
  parameter int GB_DW      = 32,
  parameter int READ_DELAY = GB_READ_DELAY_DEFAULT,
  parameter int GAP_CYCLES = GB_GAP_CYCLES_DEFAULT
) (
  input  logic             gb_clk,
  input  logic             gb_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [GB_AW-1:0] cmd_addr,
  input  logic [GB_DW-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [GB_DW-1:0] rsp_rdata,
  output logic [GB_AW-1:0] gb_addr,
  output logic [GB_DW-1:0] gb_wdata,
  output logic             gb_wen,
  output logic             gb_rstb,
  input  logic [GB_DW-1:0] gb_rdata,
  output logic             busy,
  output logic [15:0]      xact_count,
  output gb_state_e        state_dbg
);

  // Handshakes: a beat transfers on the rising edge where valid && ready are both
  // high; valid holds its payload until that edge, and ready never depends on valid.

  localparam logic [3:0] RD_LOAD  = 4'(READ_DELAY - 1);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  gb_state_e  state, state_nxt;
  logic [3:0] cnt;
  logic       out_en;
  logic       cur_write;
  logic       cmd_fire;
  logic       rsp_fire;

  // out_en keeps cmd_ready low while reset is held and for no longer than one edge after.
  assign cmd_ready = out_en && (state == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_fire) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = cur_write ? ST_RESP : ST_RWAIT;
      ST_RWAIT: if (cnt == 4'd0) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_fire) state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (cnt == 4'd0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      out_en     <= 1'b0;
      cur_write  <= 1'b0;
      cnt        <= 4'd0;
      gb_addr    <= '0;
      gb_wdata   <= '0;
      gb_wen     <= 1'b0;
      gb_rstb    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      xact_count <= 16'd0;
    end else begin
      out_en  <= 1'b1;
      gb_wen  <= 1'b0;
      gb_rstb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            cur_write <= cmd_write;
            gb_addr   <= cmd_addr;
            gb_wdata  <= cmd_write ? cmd_wdata : '0;
            gb_wen    <= cmd_write;
            gb_rstb   <= ~cmd_write;
          end
        end
        ST_ISSUE: begin
          if (cur_write) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= RD_LOAD;
          end
        end
        // gb_rdata is looked at only on this one edge, so X elsewhere never leaks in.
        ST_RWAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= gb_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_fire) begin
            rsp_valid  <= 1'b0;
            xact_count <= xact_count + 16'd1;
            cnt        <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_cmd_master.sv
// Bench for gb_cmd_master: three instances (READ_DELAY 3/1/7) against a ghostbus slave model.
module tb_gb_cmd_master;
  import gb_cmd_master_pkg::*;

  localparam int NL = 3;

  // ---------------- clock / reset ----------------
  logic gb_clk = 1'b0;
  always #5 gb_clk = ~gb_clk;

  logic        gb_rst     [NL];
  logic        cmd_valid  [NL];
  logic        cmd_ready  [NL];
  logic        cmd_write  [NL];
  logic [23:0] cmd_addr   [NL];
  logic [31:0] cmd_wdata  [NL];
  logic        rsp_valid  [NL];
  logic        rsp_ready  [NL];
  logic        rsp_write  [NL];
  logic [31:0] rsp_rdata  [NL];
  logic [23:0] gb_addr    [NL];
  logic [31:0] gb_wdata   [NL];
  logic        gb_wen     [NL];
  logic        gb_rstb    [NL];
  logic [31:0] gb_rdata   [NL];
  logic        busy       [NL];
  logic [15:0] xact_count [NL];
  gb_state_e   state_dbg  [NL];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_cnt [NL];
  int strobe_cnt [NL];
  logic x_idle = 1'b0;
  logic rand_on = 1'b0;

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q [NL][$];
  logic [56:0] bus_q [NL][$];
  logic [31:0] ref_mem [NL][64];
  logic [31:0] slv_mem [NL][64];
  logic        mem_ready = 1'b0;
  int          dly [NL];
  logic [31:0] rd_val [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    gb_cmd_master #(
      .GB_AW(24), .GB_DW(32),
      .READ_DELAY((g == 0) ? 3 : ((g == 1) ? 1 : 7)),
      .GAP_CYCLES((g == 0) ? 1 : 0)
    ) u_dut (
      .gb_clk(gb_clk), .gb_rst(gb_rst[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
      .cmd_addr(cmd_addr[g]), .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_write(rsp_write[g]),
      .rsp_rdata(rsp_rdata[g]),
      .gb_addr(gb_addr[g]), .gb_wdata(gb_wdata[g]), .gb_wen(gb_wen[g]), .gb_rstb(gb_rstb[g]),
      .gb_rdata(gb_rdata[g]), .busy(busy[g]), .xact_count(xact_count[g]), .state_dbg(state_dbg[g])
    );
  end

  function automatic int rd_of(input int l);
    return (l == 0) ? 3 : ((l == 1) ? 1 : 7);
  endfunction

  always @(posedge gb_clk) cyc++;

  // Slave: read data is valid only in the cycle before the READ_DELAY-th edge after gb_rstb.
  always @(posedge gb_clk) begin
    if (!mem_ready) begin
      for (int l = 0; l < NL; l++)
        for (int a = 0; a < 64; a++) slv_mem[l][a] = 32'h70 + 32'(a);
      mem_ready = 1'b1;
    end
    for (int l = 0; l < NL; l++) begin
      if (gb_rst[l]) begin
        dly[l] = 0;
      end else begin
        if (gb_wen[l] && gb_addr[l] < 24'd64) slv_mem[l][gb_addr[l][5:0]] = gb_wdata[l];
        if (gb_rstb[l]) begin
          dly[l] = rd_of(l);
          rd_val[l] = slv_mem[l][gb_addr[l][5:0]];
        end else if (dly[l] > 0) begin
          dly[l]--;
        end
      end
      gb_rdata[l] <= (dly[l] == 1) ? rd_val[l] : (x_idle ? 32'hxxxxxxxx : 32'hffffffff);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops bus and response expectations as the DUT produces them.
  always @(negedge gb_clk) begin
    logic [56:0] bexp;
    logic [32:0] rexp;
    #1;
    for (int l = 0; l < NL; l++) begin
      if (!gb_rst[l]) begin
        if (gb_wen[l] || gb_rstb[l]) begin
          strobe_cnt[l]++;
          check($sformatf("strobe_overlap_l%0d", l), 64'(gb_wen[l] & gb_rstb[l]), 64'd0);
          if (bus_q[l].size() == 0) begin
            check($sformatf("bus_unexpected_l%0d", l), 64'(bus_q[l].size()), 64'd1);
          end else begin
            bexp = bus_q[l].pop_front();
            check($sformatf("bus_l%0d", l), 64'({gb_wen[l], gb_addr[l], gb_wdata[l]}), 64'(bexp));
          end
        end
        if (rsp_valid[l] && rsp_ready[l]) begin
          rsp_cnt[l]++;
          if (exp_q[l].size() == 0) begin
            check($sformatf("rsp_unexpected_l%0d", l), 64'(exp_q[l].size()), 64'd1);
          end else begin
            rexp = exp_q[l].pop_front();
            check($sformatf("rsp_l%0d", l), 64'({rsp_write[l], rsp_rdata[l]}), 64'(rexp));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int l, input logic w, input logic [23:0] a, input logic [31:0] d,
                      output int acc);
    int t = 0;
    cmd_valid[l] = 1'b1;
    cmd_write[l] = w;
    cmd_addr[l]  = a;
    cmd_wdata[l] = d;
    while (!cmd_ready[l] && t < 100) begin
      @(negedge gb_clk);
      t++;
    end
    check("accept_timeout", 64'(t < 100), 64'd1);
    acc = cyc;
    if (t < 100) begin
      bus_q[l].push_back({w, a, w ? d : 32'h0});
      exp_q[l].push_back({w, w ? 32'h0 : ref_mem[l][a[5:0]]});
      if (w) ref_mem[l][a[5:0]] = d;
    end
    @(negedge gb_clk);
    cmd_valid[l] = 1'b0;
  endtask

  task automatic wait_idle(input int l);
    int t = 0;
    while ((exp_q[l].size() != 0 || busy[l]) && t < 500) begin
      @(negedge gb_clk);
      t++;
    end
    check("idle_timeout", 64'(t < 500), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int a0, a1, a2, a3, s0, r0, t;
    logic w;
    for (int l = 0; l < NL; l++) begin
      gb_rst[l] = 1'b1; cmd_valid[l] = 1'b0; cmd_write[l] = 1'b0;
      cmd_addr[l] = '0; cmd_wdata[l] = '0; rsp_ready[l] = 1'b1;
      rsp_cnt[l] = 0; strobe_cnt[l] = 0;
      for (int a = 0; a < 64; a++) ref_mem[l][a] = 32'h70 + 32'(a);
    end
    cmd_valid[0] = 1'b1;
    repeat (3) @(negedge gb_clk);
    for (int l = 0; l < NL; l++)
      check($sformatf("reset_outputs_l%0d", l),
            64'({cmd_ready[l], busy[l], rsp_valid[l], gb_wen[l], gb_rstb[l], xact_count[l], gb_addr[l]}),
            64'd0);
    for (int l = 0; l < NL; l++) gb_rst[l] = 1'b0;
    cmd_valid[0] = 1'b0;
    @(negedge gb_clk);
    for (int l = 0; l < NL; l++) check($sformatf("ready_after_reset_l%0d", l), 64'(cmd_ready[l]), 64'd1);

    // Write then read back address 0.
    send(0, 1'b1, 24'h0, 32'hcc, a0);
    send(0, 1'b0, 24'h0, 32'h0, a1);
    wait_idle(0);
    check("xact_after_wr_rd", 64'(xact_count[0]), 64'd2);

    // Exact sample edge for READ_DELAY 3, 1, 7.
    for (int l = 0; l < NL; l++) begin
      send(l, 1'b1, 24'h5, 32'hdeadbeef, a0);
      send(l, 1'b0, 24'h5, 32'h0, a1);
      wait_idle(l);
    end

    // Back-to-back spacing.
    send(0, 1'b1, 24'h20, 32'h11, a0);
    send(0, 1'b0, 24'h20, 32'h0, a1);
    send(0, 1'b1, 24'h21, 32'h22, a2);
    send(0, 1'b0, 24'h21, 32'h0, a3);
    check("spacing_w_gap1", 64'(a1 - a0), 64'd4);
    check("spacing_r_gap1", 64'(a2 - a1), 64'd7);
    check("spacing_w2_gap1", 64'(a3 - a2), 64'd4);
    wait_idle(0);
    send(1, 1'b1, 24'h22, 32'h33, a0);
    send(1, 1'b1, 24'h23, 32'h44, a1);
    check("spacing_w_gap0", 64'(a1 - a0), 64'd3);
    wait_idle(1);
    send(2, 1'b0, 24'h22, 32'h0, a0);
    send(2, 1'b1, 24'h23, 32'h55, a1);
    check("spacing_r_rd7", 64'(a1 - a0), 64'd10);
    wait_idle(2);

    // Response backpressure holds the response and blocks new commands.
    rsp_ready[0] = 1'b0;
    s0 = strobe_cnt[0];
    send(0, 1'b0, 24'h10, 32'h0, a0);
    t = 0;
    while (!rsp_valid[0] && t < 50) begin
      @(negedge gb_clk);
      t++;
    end
    check("bp_rsp_timeout", 64'(t < 50), 64'd1);
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 24'h30; cmd_wdata[0] = 32'h99;
    for (int i = 0; i < 10; i++) begin
      @(negedge gb_clk);
      check("bp_hold", 64'({rsp_valid[0], rsp_rdata[0], cmd_ready[0]}), {31'd0, 1'b1, 32'h80, 1'b0});
    end
    check("bp_no_strobe", 64'(strobe_cnt[0] - s0), 64'd1);
    cmd_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    wait_idle(0);

    // Reset during RWAIT on lane 0 and during ISSUE on lane 1.
    r0 = rsp_cnt[0];
    send(0, 1'b0, 24'h11, 32'h0, a0);
    @(negedge gb_clk);
    check("pre_reset_state", 64'({busy[0], state_dbg[0]}), 64'({1'b1, ST_RWAIT}));
    #2 gb_rst[0] = 1'b1;
    #1 check("reset_rwait", 64'({gb_rstb[0], rsp_valid[0], busy[0], cmd_ready[0], xact_count[0]}), 64'd0);
    exp_q[0].delete();
    @(negedge gb_clk);
    gb_rst[0] = 1'b0;
    send(1, 1'b0, 24'h12, 32'h0, a1);
    #2 gb_rst[1] = 1'b1;
    #1 check("reset_issue", 64'({gb_rstb[1], rsp_valid[1], busy[1]}), 64'd0);
    exp_q[1].delete();
    @(negedge gb_clk);
    gb_rst[1] = 1'b0;
    repeat (10) @(negedge gb_clk);
    check("no_rsp_after_reset", 64'(rsp_cnt[0] - r0), 64'd0);
    check("xact_cleared", 64'(xact_count[0]), 64'd0);
    send(0, 1'b0, 24'h11, 32'h0, a0);
    wait_idle(0);
    check("xact_after_reset", 64'(xact_count[0]), 64'd1);

    // Random mix against the reference memory, X on idle read data.
    r0 = rsp_cnt[0];
    x_idle = 1'b1;
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          w = 1'($urandom_range(0, 1));
          send(0, w, 24'($urandom_range(0, 63)), $urandom, a0);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge gb_clk);
        end
        wait_idle(0);
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(negedge gb_clk);
          if (rand_on) rsp_ready[0] = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready[0] = 1'b1;
    check("random_rsp_count", 64'(rsp_cnt[0] - r0), 64'd1000);
    check("random_xact", 64'(xact_count[0]), 64'd1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
